// File: rtl/router_fifo_buf.sv
// Per-output-port packet buffer: byte FIFO with start-of-packet tags, a packet
// counter and an idle watchdog that flushes a stalled, unread buffer.
module router_fifo_buf #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                     clk1,
  input  logic                     reset,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     sop_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     read_enb,
  output logic [WIDTH-1:0]         data_out,
  output logic                     sop_out,
  output logic                     data_valid,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Holds values up to TIMEOUT-1, the largest the watchdog ever stores.
  localparam int unsigned IW = $clog2(TIMEOUT);

  logic [WIDTH:0]   mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             sop_out_q, sop_out_d;
  logic             data_valid_q, data_valid_d;
  logic             timeout_q, timeout_d;

  logic             wr_acc, rd_acc, idle_inc, auto_flush, flush, mem_we;
  logic [WIDTH:0]   rd_word;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  assign wr_acc     = write_enb && !fifo_full;
  assign rd_acc     = read_enb && !fifo_empty;
  assign idle_inc   = !fifo_empty && !read_enb;
  assign auto_flush = idle_inc && (idle_cnt_q == IW'(TIMEOUT - 1));
  assign flush      = soft_reset || auto_flush;
  assign mem_we     = wr_acc && !flush;
  assign rd_word    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pkt_cnt_d    = pkt_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    data_out_d   = data_out_q;
    sop_out_d    = sop_out_q;
    data_valid_d = 1'b0;
    timeout_d    = 1'b0;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pkt_cnt_d  = '0;
      idle_cnt_d = '0;
      timeout_d  = !soft_reset;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        data_out_d   = rd_word[WIDTH-1:0];
        sop_out_d    = rd_word[WIDTH];
        data_valid_d = 1'b1;
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      unique case ({wr_acc && sop_in, rd_acc && rd_word[WIDTH]})
        2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
        2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
        default: pkt_cnt_d = pkt_cnt_q;
      endcase

      idle_cnt_d = idle_inc ? idle_cnt_q + IW'(1) : '0;
    end
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      data_out_q   <= '0;
      sop_out_q    <= 1'b0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_cnt_q    <= pkt_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      data_out_q   <= data_out_d;
      sop_out_q    <= sop_out_d;
      data_valid_q <= data_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  // Storage is deliberately unreset; count gates every read.
  always_ff @(posedge clk1) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= {sop_in, data_in};
    end
  end

  assign data_out   = data_out_q;
  assign sop_out    = sop_out_q;
  assign data_valid = data_valid_q;
  assign pkt_count  = pkt_cnt_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_router_fifo_buf.sv
// Directed self-checking bench for router_fifo_buf (DEPTH 16, WIDTH 8, TIMEOUT 30).
module tb_router_fifo_buf;

  logic       clk1 = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       sop_in;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       sop_out;
  logic       data_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] pkt_count;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  router_fifo_buf #(
    .DEPTH  (16),
    .WIDTH  (8),
    .TIMEOUT(30)
  ) dut (
    .clk1      (clk1),
    .reset     (reset),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .sop_in    (sop_in),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .data_valid(data_valid),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .pkt_count (pkt_count),
    .timeout   (timeout)
  );

  always #5 clk1 = ~clk1;

  // Drive one cycle of requests, then sample 1ns after the capturing edge.
  task automatic step(input logic we, input logic sp, input logic [7:0] d, input logic re);
    write_enb = we;
    sop_in    = sp;
    data_in   = d;
    read_enb  = re;
    @(posedge clk1);
    #1;
    write_enb = 1'b0;
    sop_in    = 1'b0;
    read_enb  = 1'b0;
  endtask

  task automatic flush_soft();
    soft_reset = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    soft_reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", data_out); end
    n_cmp++; if (sop_out !== 1'b0) begin n_bad++; $display("FAIL rst_sop got %b want 0", sop_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", data_valid); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", fifo_full); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b want 1", fifo_empty); end
    n_cmp++; if (pkt_count !== 5'd0) begin n_bad++; $display("FAIL rst_pkt got %0d want 0", pkt_count); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout got %b want 0", timeout); end
    repeat (2) @(posedge clk1);
    #1 reset = 1'b1;
  endtask

  task automatic test_basic();
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b0);
    step(1'b1, 1'b0, 8'h11, 1'b0);
    n_cmp++; if (fifo_empty !== 1'b0) begin n_bad++; $display("FAIL basic_empty got %b want 0", fifo_empty); end
    n_cmp++; if (pkt_count !== 5'd1) begin n_bad++; $display("FAIL basic_pkt got %0d want 1", pkt_count); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL basic_novalid got %b want 0", data_valid); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({data_valid, sop_out, data_out} !== {1'b1, 1'b1, 8'hA5}) begin
      n_bad++; $display("FAIL basic_rd0 got v%b s%b %h want v1 s1 a5", data_valid, sop_out, data_out);
    end
    n_cmp++; if (pkt_count !== 5'd0) begin n_bad++; $display("FAIL basic_pkt0 got %0d want 0", pkt_count); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({data_valid, sop_out, data_out} !== {1'b1, 1'b0, 8'h03}) begin
      n_bad++; $display("FAIL basic_rd1 got v%b s%b %h want v1 s0 03", data_valid, sop_out, data_out);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({data_valid, sop_out, data_out} !== {1'b1, 1'b0, 8'h11}) begin
      n_bad++; $display("FAIL basic_rd2 got v%b s%b %h want v1 s0 11", data_valid, sop_out, data_out);
    end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty_end got %b want 1", fifo_empty); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({data_valid, data_out} !== {1'b0, 8'h11}) begin
      n_bad++; $display("FAIL basic_hold got v%b %h want v0 11", data_valid, data_out);
    end
  endtask

  task automatic test_full();
    flush_soft();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 14) begin
        n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL full_at15 got %b want 0", fifo_full); end
      end
    end
    n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL full_at16 got %b want 1", fifo_full); end
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL full_drop got %b want 1", fifo_full); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if ({data_valid, data_out} !== {1'b1, 8'(i)}) begin
        n_bad++; $display("FAIL full_rd%0d got v%b %h want v1 %h", i, data_valid, data_out, 8'(i));
      end
    end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL full_drained got %b want 1", fifo_empty); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL full_noff got v%b want 0", data_valid); end
  endtask

  task automatic test_simultaneous();
    flush_soft();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b1);
    n_cmp++; if ({data_valid, data_out, fifo_full} !== {1'b1, 8'h00, 1'b0}) begin
      n_bad++; $display("FAIL sim_full got v%b %h f%b want v1 00 f0", data_valid, data_out, fifo_full);
    end
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (data_out !== 8'(i)) begin
        n_bad++; $display("FAIL sim_rd%0d got %h want %h", i, data_out, 8'(i));
      end
    end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL sim_no55 got empty %b want 1", fifo_empty); end
    step(1'b1, 1'b0, 8'h77, 1'b1);
    n_cmp++; if ({data_valid, fifo_empty, data_out} !== {1'b0, 1'b0, 8'h0F}) begin
      n_bad++; $display("FAIL sim_empty got v%b e%b %h want v0 e0 0f", data_valid, fifo_empty, data_out);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({data_valid, data_out} !== {1'b1, 8'h77}) begin
      n_bad++; $display("FAIL sim_late got v%b %h want v1 77", data_valid, data_out);
    end
  endtask

  task automatic test_wrap();
    logic ok;
    flush_soft();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (data_out !== 8'h10 + 8'(i)) begin
        n_bad++; $display("FAIL wrap_a%0d got %h want %h", i, data_out, 8'h10 + 8'(i));
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if ({data_valid, data_out} !== {1'b1, 8'h40 + 8'(i)}) begin
        n_bad++; $display("FAIL wrap_b%0d got v%b %h want v1 %h", i, data_valid, data_out, 8'h40 + 8'(i));
      end
    end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_timeout();
    logic early;
    flush_soft();
    step(1'b1, 1'b1, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    early = 1'b0;
    for (int i = 0; i < 28; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (fifo_empty || timeout) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL to_early got flush %b want 0", early); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if ({fifo_empty, timeout, pkt_count} !== {1'b1, 1'b1, 5'd0}) begin
      n_bad++; $display("FAIL to_fire got e%b t%b p%0d want e1 t1 p0", fifo_empty, timeout, pkt_count);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse got %b want 0", timeout); end

    flush_soft();
    step(1'b1, 1'b1, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({data_valid, sop_out, data_out} !== {1'b1, 1'b1, 8'h01}) begin
      n_bad++; $display("FAIL to_rd20 got v%b s%b %h want v1 s1 01", data_valid, sop_out, data_out);
    end
    early = 1'b0;
    for (int i = 0; i < 29; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (fifo_empty || timeout) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL to_restart got flush %b want 0", early); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if ({fifo_empty, timeout} !== {1'b1, 1'b1}) begin
      n_bad++; $display("FAIL to_fire2 got e%b t%b want e1 t1", fifo_empty, timeout);
    end
  endtask

  task automatic test_soft_reset();
    flush_soft();
    step(1'b1, 1'b1, 8'h61, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h62 + 8'(i), 1'b0);
    n_cmp++; if (pkt_count !== 5'd1) begin n_bad++; $display("FAIL sr_pre got %0d want 1", pkt_count); end
    soft_reset = 1'b1;
    step(1'b1, 1'b1, 8'h99, 1'b0);
    soft_reset = 1'b0;
    n_cmp++; if ({fifo_empty, fifo_full, pkt_count, timeout} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      n_bad++; $display("FAIL sr_flush got e%b f%b p%0d t%b want e1 f0 p0 t0",
                        fifo_empty, fifo_full, pkt_count, timeout);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL sr_discard got v%b want 0", data_valid); end
    step(1'b1, 1'b0, 8'h42, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({data_valid, data_out} !== {1'b1, 8'h42}) begin
      n_bad++; $display("FAIL sr_after got v%b %h want v1 42", data_valid, data_out);
    end
  endtask

  task automatic test_async_reset();
    flush_soft();
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    step(1'b1, 1'b0, 8'hC4, 1'b1);
    write_enb = 1'b1;
    data_in   = 8'hC5;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({data_out, sop_out, data_valid, fifo_full, fifo_empty, pkt_count, timeout} !==
                 {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      n_bad++; $display("FAIL ar_now got d%h s%b v%b f%b e%b p%0d t%b want d00 s0 v0 f0 e1 p0 t0",
                        data_out, sop_out, data_valid, fifo_full, fifo_empty, pkt_count, timeout);
    end
    write_enb = 1'b0;
    @(posedge clk1);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({data_valid, data_out} !== {1'b0, 8'h00}) begin
      n_bad++; $display("FAIL ar_stale got v%b %h want v0 00", data_valid, data_out);
    end
  endtask

  initial begin
    reset      = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    sop_in     = 1'b0;
    data_in    = 8'h00;
    read_enb   = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_simultaneous();
    test_wrap();
    test_timeout();
    test_soft_reset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/router_fifo_buf.md
# router_fifo_buf

Per-output-port packet buffer sitting directly downstream of the router FSM: it accepts the byte stream written under the FSM's write enable, supplies the `fifo_full` back-pressure the FSM stalls on, and presents bytes to the output port's reader. Each entry carries a start-of-packet tag (sourced from the FSM's `get_dest` strobe). The block also keeps a count of buffered packets and self-flushes when an unread packet sits idle past a timeout.

## Interface
- `DEPTH`, 16: entries; power of two, ≥ 4.
- `WIDTH`, 8: data byte width.
- `TIMEOUT`, 30: consecutive unread cycles before auto-flush; ≥ 2.
- `clk1` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `soft_reset` in 1: synchronous, active-high flush request.
- `write_enb` in 1: write request from router FSM.
- `sop_in` in 1: tags the byte written this cycle as first byte of a packet.
- `data_in` in `WIDTH`: byte to write.
- `read_enb` in 1: read request from output port.
- `data_out` out `WIDTH`: registered read data.
- `sop_out` out 1: registered tag of the byte on `data_out`.
- `data_valid` out 1: `data_out`/`sop_out` updated this cycle.
- `fifo_full` out 1: `count == DEPTH`.
- `fifo_empty` out 1: `count == 0`.
- `pkt_count` out log2(`DEPTH`)+1: tagged entries currently stored.
- `timeout` out 1: one-cycle pulse after an auto-flush.

## Operation
- Storage: `DEPTH` × (`WIDTH`+1); bit `WIDTH` holds the tag. Write and read pointers log2(`DEPTH`) bits, wrap `DEPTH-1`→0. Occupancy register `count` 0..`DEPTH`.
- Write accepted iff `write_enb && !fifo_full`: `mem[wr_ptr] <= {sop_in, data_in}`, `wr_ptr++`. Rejected writes are dropped silently, no state change.
- Read accepted iff `read_enb && !fifo_empty`: `data_out`/`sop_out` <= `mem[rd_ptr]`, `rd_ptr++`, `data_valid` <= 1; else `data_valid` <= 0, `data_out`/`sop_out` hold.
- `count`: +1 write only, -1 read only, unchanged both/neither. Full + both requested → read only. Empty + both → write only (no fall-through).
- `pkt_count`: +1 on accepted write with `sop_in`, -1 on accepted read of tagged entry, net 0 if both.
- Watchdog `idle_cnt`: increments when `!fifo_empty && !read_enb`; clears when `read_enb` high or `fifo_empty`. When `idle_cnt == TIMEOUT-1` and increment condition holds → flush at that edge.
- Flush (auto or `soft_reset`): pointers, `count`, `pkt_count`, `idle_cnt` <= 0; `data_valid` <= 0; `data_out`/`sop_out` hold. Any write/read that cycle discarded. Auto-flush sets `timeout` <= 1 for one cycle; `soft_reset` does not.
- Priority: `reset` > `soft_reset` > auto-flush > normal access.
- Memory contents not reset; not observable since `count` gates reads.

## Timing
- Reset (async, immediate): `data_out` 0, `sop_out` 0, `data_valid` 0, `fifo_full` 0, `fifo_empty` 1, `pkt_count` 0, `timeout` 0; all pointers/counters 0. Release synchronous to next edge.
- Read latency 1: read at edge N → data on `data_out`, `data_valid` high, cycle after N.
- Flags combinational from registered `count`: reflect accepted accesses the cycle after the edge. Write at edge N on last free slot → `fifo_full` high after N; FSM sees it for the cycle N+1 decision.
- Write-to-read: byte written at edge N readable at edge N+1, on `data_out` after N+1.
- Auto-flush fires at the edge ending the `TIMEOUT`-th consecutive qualifying cycle; `timeout` high for the following cycle only.

## Test plan
- Reset then write 0xA5 (sop=1), 0x03, 0x11, no reads → `count` 3, `pkt_count` 1, `fifo_empty` 0; read ×3 → 0xA5/sop 1, 0x03, 0x11 each one cycle after its `read_enb`; `fifo_empty` 1, `pkt_count` 0.
- Write 16 bytes 0x00..0x0F → `fifo_full` 1 after 16th edge; 17th write 0xFF dropped; read all → 0x00..0x0F, 0xFF absent.
- Full, `read_enb` and `write_enb` (0x55) same cycle → only read accepted, `count` 15, `fifo_full` 0; empty + both → write only, `data_valid` 0.
- Wrap: 10 writes/10 reads, then 12 writes/12 reads interleaved → data order preserved across pointer wrap, `count` returns 0.
- Write 2 bytes, hold `read_enb` low 29 cycles → no flush; 30th cycle → flush, `fifo_empty` 1, `timeout` single-cycle pulse. Repeat with one `read_enb` at cycle 20 → counter restarts, no flush at 30.
- `soft_reset` with 5 entries and concurrent write → `count` 0, `pkt_count` 0, `timeout` 0, write discarded; assert `reset` mid-burst → all outputs reset values immediately, pre-reset data never read out.
